// File: rtl/mpeg_ps_multi_demuxer_pkg.sv
// Shared types and start-code constants for the MPEG-1 program-stream demultiplexer.
package mpeg_ps_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_Z1, S_Z2, S_CODE, S_PACK, S_LEN_HI, S_LEN_LO,
      S_HDR, S_STD1, S_PTS, S_DTS, S_PAYLOAD, S_SKIP
   } state_e;

   localparam logic [7:0] SC_PACK    = 8'hBA;
   localparam logic [7:0] SC_END     = 8'hB9;
   localparam logic [7:0] SC_SYS_HDR = 8'hBB;
   localparam logic [7:0] SC_PAD     = 8'hBE;

   typedef logic [32:0] ts_t;

   function automatic int chan_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_av_code(input logic [7:0] c);
      return (c >= 8'hC0) && (c <= 8'hEF);
   endfunction

endpackage

// File: rtl/mpeg_ps_ts_field.sv
// Assembles a 33-bit SCR/PTS/DTS from its 5-byte field; value includes the current byte.
module mpeg_ps_ts_field
   import mpeg_ps_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] idx,
   input  logic [7:0] data,
   output ts_t        value,
   output logic       marker_ok
);

   ts_t acc_q, acc_d;

   always_comb begin
      value = (idx == 3'd0) ? '0 : acc_q;
      case (idx)
         3'd0:    value[32:30] = data[3:1];
         3'd1:    value[29:22] = data;
         3'd2:    value[21:15] = data[7:1];
         3'd3:    value[14:7]  = data;
         default: value[6:0]   = data[7:1];
      endcase
      // bytes 1 and 3 carry no marker bit
      marker_ok = (idx == 3'd1) || (idx == 3'd3) || data[0];
      acc_d     = load ? value : acc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/mpeg_ps_multi_demuxer.sv
// MPEG-1 program-stream demultiplexer: parses pack/packet headers and routes
// payload of stream IDs matching per-channel filters.
module mpeg_ps_multi_demuxer
   import mpeg_ps_pkg::*;
#(
   parameter int NUM_STREAMS = 2,
   parameter int MAX_STUFF   = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [7:0]                          in_data,
   input  logic                                in_valid,
   input  logic [31:0]                         dclk,
   input  logic [8*NUM_STREAMS-1:0]            cfg_id,
   input  logic [8*NUM_STREAMS-1:0]            cfg_mask,
   input  logic [NUM_STREAMS-1:0]              cfg_en,
   output logic [7:0]                          out_data,
   output logic                                out_valid,
   output logic [chan_bits(NUM_STREAMS)-1:0]   out_chan,
   output logic                                out_first,
   output logic [33*NUM_STREAMS-1:0]           pts,
   output logic [NUM_STREAMS-1:0]              pts_valid,
   output logic [32:0]                         scr,
   output logic                                scr_valid,
   output logic [32:0]                         start_time,
   output logic                                start_valid,
   output logic                                end_code
);

   localparam int CHW = chan_bits(NUM_STREAMS);
   localparam int SW  = $clog2(MAX_STUFF + 1);

   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [15:0]        len_q, len_d;
   logic [7:0]         code_q, code_d;
   logic [CHW-1:0]     chan_q, chan_d;
   logic [SW-1:0]      stuff_q, stuff_d;
   logic               has_dts_q, has_dts_d;
   logic               first_q, first_d;
   logic               scr_seen_q, scr_seen_d;
   logic [7:0]         out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic [CHW-1:0]     out_chan_q, out_chan_d;
   logic               out_first_q, out_first_d;
   ts_t                pts_q [NUM_STREAMS];
   ts_t                pts_d [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] pts_valid_q, pts_valid_d;
   ts_t                scr_q, scr_d;
   logic               scr_valid_q, scr_valid_d;
   ts_t                start_time_q, start_time_d;
   logic               start_valid_q, start_valid_d;
   logic               end_code_q, end_code_d;

   logic               match;
   logic [CHW-1:0]     match_c;
   logic               ts_load, marker_ok;
   logic [2:0]         ts_idx;
   ts_t                ts_value;

   assign ts_load = in_valid && ((state_q == S_PACK && idx_q < 3'd5) || state_q == S_HDR ||
                                 state_q == S_PTS || state_q == S_DTS);
   assign ts_idx  = (state_q == S_HDR) ? 3'd0 : idx_q;

   mpeg_ps_ts_field u_ts_field (
      .clk       (clk),
      .reset     (reset),
      .load      (ts_load),
      .idx       (ts_idx),
      .data      (in_data),
      .value     (ts_value),
      .marker_ok (marker_ok)
   );

   // lowest enabled channel whose masked ID matches wins
   always_comb begin
      match   = 1'b0;
      match_c = '0;
      for (int unsigned c = 0; c < NUM_STREAMS; c++) begin
         if (!match && cfg_en[c] &&
             (((code_q ^ cfg_id[c*8 +: 8]) & cfg_mask[c*8 +: 8]) == 8'h00)) begin
            match   = 1'b1;
            match_c = CHW'(c);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      len_d         = len_q;
      code_d        = code_q;
      chan_d        = chan_q;
      stuff_d       = stuff_q;
      has_dts_d     = has_dts_q;
      first_d       = first_q;
      scr_seen_d    = scr_seen_q;
      out_data_d    = out_data_q;
      out_valid_d   = 1'b0;
      out_chan_d    = out_chan_q;
      out_first_d   = 1'b0;
      pts_d         = pts_q;
      pts_valid_d   = '0;
      scr_d         = scr_q;
      scr_valid_d   = 1'b0;
      start_time_d  = start_time_q;
      start_valid_d = start_valid_q;
      end_code_d    = 1'b0;

      if (in_valid) begin
         case (state_q)
            S_IDLE: if (in_data == 8'h00) state_d = S_Z1;
            S_Z1:   state_d = (in_data == 8'h00) ? S_Z2 : S_IDLE;
            S_Z2:   if (in_data == 8'h01) state_d = S_CODE;
                    else if (in_data != 8'h00) state_d = S_IDLE;
            S_CODE: begin
               code_d = in_data;
               idx_d  = 3'd0;
               if (in_data == SC_PACK)          state_d = S_PACK;
               else if (in_data == SC_END)      begin end_code_d = 1'b1; state_d = S_IDLE; end
               else if (in_data >= SC_SYS_HDR)  state_d = S_LEN_HI;
               else                             state_d = S_IDLE;
            end
            S_PACK: begin
               if (idx_q == 3'd0 && !(in_data[7:4] == 4'b0010 && in_data[0])) begin
                  state_d = S_IDLE;
               end else begin
                  if (idx_q == 3'd4) begin
                     scr_d       = ts_value;
                     scr_valid_d = 1'b1;
                     scr_seen_d  = 1'b1;
                  end
                  if (idx_q == 3'd7) state_d = S_IDLE;
                  idx_d = idx_q + 3'd1;
               end
            end
            S_LEN_HI: begin
               len_d   = {in_data, 8'h00};
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d   = {len_q[15:8], in_data};
               stuff_d = '0;
               chan_d  = match_c;
               if ({len_q[15:8], in_data} == 16'h0000)  state_d = S_IDLE;
               else if (is_av_code(code_q) && match)    state_d = S_HDR;
               else                                     state_d = S_SKIP;
            end
            default: begin
               len_d = len_q - 16'd1;
               case (state_q)
                  S_HDR: begin
                     if (in_data == 8'hFF) begin
                        if (stuff_q == SW'(MAX_STUFF)) state_d = S_SKIP;
                        else                           stuff_d = stuff_q + SW'(1);
                     end else if (in_data[7:6] == 2'b01) begin
                        state_d = S_STD1;
                     end else if (in_data[7:5] == 3'b001 && in_data[0]) begin
                        state_d   = S_PTS;
                        idx_d     = 3'd1;
                        has_dts_d = in_data[4];
                     end else if (in_data == 8'h0F) begin
                        state_d = S_PAYLOAD;
                        first_d = 1'b1;
                     end else begin
                        state_d = S_SKIP;
                     end
                  end
                  S_STD1: state_d = S_HDR;
                  S_PTS: begin
                     if (!marker_ok) begin
                        state_d = S_SKIP;
                     end else if (idx_q == 3'd4) begin
                        for (int unsigned c = 0; c < NUM_STREAMS; c++) begin
                           if (CHW'(c) == chan_q) begin
                              pts_d[c]       = ts_value;
                              pts_valid_d[c] = 1'b1;
                           end
                        end
                        // SCR is 90 kHz, dclk 45 kHz: work at half resolution
                        if (chan_q == '0 && !start_valid_q && scr_seen_q) begin
                           start_time_d  = {dclk + ts_value[32:1] - scr_q[32:1], 1'b0};
                           start_valid_d = 1'b1;
                        end
                        idx_d   = 3'd0;
                        state_d = has_dts_q ? S_DTS : S_PAYLOAD;
                        first_d = 1'b1;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  S_DTS: begin
                     if (!marker_ok)            state_d = S_SKIP;
                     else if (idx_q == 3'd4)    begin state_d = S_PAYLOAD; first_d = 1'b1; end
                     else                       idx_d = idx_q + 3'd1;
                  end
                  S_PAYLOAD: begin
                     out_data_d  = in_data;
                     out_valid_d = 1'b1;
                     out_chan_d  = chan_q;
                     out_first_d = first_q;
                     first_d     = 1'b0;
                  end
                  default: ;
               endcase
               // the packet length bounds everything, even an unfinished header
               if (len_q == 16'd1) state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         len_q         <= '0;
         code_q        <= '0;
         chan_q        <= '0;
         stuff_q       <= '0;
         has_dts_q     <= 1'b0;
         first_q       <= 1'b0;
         scr_seen_q    <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_chan_q    <= '0;
         out_first_q   <= 1'b0;
         for (int unsigned c = 0; c < NUM_STREAMS; c++) pts_q[c] <= '0;
         pts_valid_q   <= '0;
         scr_q         <= '0;
         scr_valid_q   <= 1'b0;
         start_time_q  <= '0;
         start_valid_q <= 1'b0;
         end_code_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         code_q        <= code_d;
         chan_q        <= chan_d;
         stuff_q       <= stuff_d;
         has_dts_q     <= has_dts_d;
         first_q       <= first_d;
         scr_seen_q    <= scr_seen_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_chan_q    <= out_chan_d;
         out_first_q   <= out_first_d;
         pts_q         <= pts_d;
         pts_valid_q   <= pts_valid_d;
         scr_q         <= scr_d;
         scr_valid_q   <= scr_valid_d;
         start_time_q  <= start_time_d;
         start_valid_q <= start_valid_d;
         end_code_q    <= end_code_d;
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_STREAMS; c++) pts[c*33 +: 33] = pts_q[c];
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign out_chan    = out_chan_q;
   assign out_first   = out_first_q;
   assign pts_valid   = pts_valid_q;
   assign scr         = scr_q;
   assign scr_valid   = scr_valid_q;
   assign start_time  = start_time_q;
   assign start_valid = start_valid_q;
   assign end_code    = end_code_q;

endmodule

// File: tb/tb_mpeg_ps_multi_demuxer.sv
// Directed bench for mpeg_ps_multi_demuxer with a payload scoreboard.
module tb_mpeg_ps_multi_demuxer;

   localparam int NS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [31:0] dclk;
   logic [15:0] cfg_id, cfg_mask;
   logic [1:0]  cfg_en;
   logic [7:0]  out_data;
   logic        out_valid, out_chan, out_first;
   logic [65:0] pts;
   logic [1:0]  pts_valid;
   logic [32:0] scr, start_time;
   logic        scr_valid, start_valid, end_code;

   always #5 clk = ~clk;

   mpeg_ps_multi_demuxer #(.NUM_STREAMS(NS), .MAX_STUFF(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .dclk(dclk),
      .cfg_id(cfg_id), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
      .out_data(out_data), .out_valid(out_valid), .out_chan(out_chan), .out_first(out_first),
      .pts(pts), .pts_valid(pts_valid), .scr(scr), .scr_valid(scr_valid),
      .start_time(start_time), .start_valid(start_valid), .end_code(end_code)
   );

   int vectors = 0, miscompares = 0;
   int scr_cnt = 0, pts0_cnt = 0, pts1_cnt = 0, end_cnt = 0;
   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   logic [7:0] pkt[$];

   always @(negedge clk) begin
      if (out_valid)    obs_q.push_back({out_chan, out_first, out_data});
      if (scr_valid)    scr_cnt++;
      if (pts_valid[0]) pts0_cnt++;
      if (pts_valid[1]) pts1_cnt++;
      if (end_code)     end_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send(pkt[i]);
      pkt.delete();
   endtask

   function automatic void add_start(input logic [7:0] code);
      pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(code);
   endfunction

   function automatic void add_len(input logic [15:0] l);
      pkt.push_back(l[15:8]); pkt.push_back(l[7:0]);
   endfunction

   function automatic void add_ts(input logic [3:0] pre, input logic [32:0] v);
      pkt.push_back({pre, v[32:30], 1'b1});
      pkt.push_back(v[29:22]);
      pkt.push_back({v[21:15], 1'b1});
      pkt.push_back(v[14:7]);
      pkt.push_back({v[6:0], 1'b1});
   endfunction

   function automatic void add_pay(input logic [7:0] b, input logic ch, input logic first);
      pkt.push_back(b);
      exp_q.push_back({ch, first, b});
   endfunction

   task automatic send_pack(input logic [32:0] v);
      add_start(8'hBA);
      add_ts(4'b0010, v);
      pkt.push_back(8'h80); pkt.push_back(8'h00); pkt.push_back(8'h01);
      send_pkt();
   endtask

   task automatic drain(input string tag);
      logic [9:0] o, e;
      repeat (4) @(negedge clk);
      chk({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk(tag, 64'(o), 64'(e));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   int s0, p0, p1, e0;

   initial begin
      in_data = '0; in_valid = 1'b0; dclk = '0;
      cfg_id = {8'hC0, 8'hE0}; cfg_mask = 16'hFFFF; cfg_en = 2'b01;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst out_valid",   64'(out_valid), 64'd0);
      chk("rst scr",         64'(scr), 64'd0);
      chk("rst pts",         64'(pts), 64'd0);
      chk("rst start_valid", 64'(start_valid), 64'd0);
      chk("rst end_code",    64'(end_code), 64'd0);

      // E0 packet, PTS 90000, three payload bytes, no SCR seen yet
      add_start(8'hE0); add_len(16'd8); add_ts(4'b0010, 33'd90000);
      add_pay(8'hAA, 1'b0, 1'b1); add_pay(8'hBB, 1'b0, 1'b0); add_pay(8'hCC, 1'b0, 1'b0);
      send_pkt();
      drain("t2 payload");
      chk("t2 pts0",        64'(pts[32:0]), 64'd90000);
      chk("t2 pts0 pulses", 64'(pts0_cnt), 64'd1);
      chk("t2 no start",    64'(start_valid), 64'd0);

      reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;

      // pack header SCR
      s0 = scr_cnt;
      send_pack(33'h1_2345_6788);
      drain("t1 no payload");
      chk("t1 scr",        64'(scr), 64'h1_2345_6788);
      chk("t1 scr pulses", 64'(scr_cnt - s0), 64'd1);

      // start time from pack SCR 400 and PTS 1000
      send_pack(33'd400);
      dclk = 32'd5000;
      add_start(8'hE0); add_len(16'd6); add_ts(4'b0010, 33'd1000); add_pay(8'h11, 1'b0, 1'b1);
      send_pkt();
      drain("t3 payload");
      chk("t3 start_valid", 64'(start_valid), 64'd1);
      chk("t3 start_time",  64'(start_time), 64'd10600);
      dclk = 32'd9999;
      add_start(8'hE0); add_len(16'd6); add_ts(4'b0010, 33'd2000); add_pay(8'h22, 1'b0, 1'b1);
      send_pkt();
      drain("t3b payload");
      chk("t3b start_time held", 64'(start_time), 64'd10600);
      chk("t3b pts0",            64'(pts[32:0]), 64'd2000);

      // unmatched C0 with only channel 0 enabled
      p1 = pts1_cnt;
      add_start(8'hC0); add_len(16'd6); add_ts(4'b0010, 33'd3); pkt.push_back(8'h33);
      send_pkt();
      drain("t4 skipped");
      chk("t4 no pts1", 64'(pts1_cnt - p1), 64'd0);
      send_pack(33'h0_0000_1234);
      chk("t4 next pack scr", 64'(scr), 64'h1234);

      // 17 stuffing bytes exceeds the limit
      add_start(8'hE0); add_len(16'd20);
      repeat (17) pkt.push_back(8'hFF);
      pkt.push_back(8'h0F); pkt.push_back(8'h44); pkt.push_back(8'h55);
      send_pkt();
      drain("t5 overstuffed");
      // length ends inside the PTS
      p0 = pts0_cnt;
      add_start(8'hE0); add_len(16'd3); add_ts(4'b0010, 33'd4444);
      void'(pkt.pop_back()); void'(pkt.pop_back());
      send_pkt();
      drain("t5 short");
      chk("t5 short no pts", 64'(pts0_cnt - p0), 64'd0);
      chk("t5 short pts0",   64'(pts[32:0]), 64'd2000);
      // exactly 16 stuffing bytes is accepted
      add_start(8'hE0); add_len(16'd19);
      repeat (16) pkt.push_back(8'hFF);
      pkt.push_back(8'h0F); add_pay(8'h66, 1'b0, 1'b1); add_pay(8'h77, 1'b0, 1'b0);
      send_pkt();
      drain("t5 stuff16");
      // channel 1 with STD, PTS and DTS
      cfg_en = 2'b11;
      add_start(8'hC0); add_len(16'd14);
      pkt.push_back(8'h40); pkt.push_back(8'h20);
      add_ts(4'b0011, 33'd3000); add_ts(4'b0001, 33'd2500);
      add_pay(8'h5A, 1'b1, 1'b1); add_pay(8'hA5, 1'b1, 1'b0);
      send_pkt();
      drain("ch1 payload");
      chk("ch1 pts1", 64'(pts[65:33]), 64'd3000);

      // padding packet then end code
      e0 = end_cnt;
      pkt.push_back(8'h00); add_start(8'hBE); add_len(16'd4);
      pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33); pkt.push_back(8'h44);
      add_start(8'hB9);
      send_pkt();
      drain("t6 padding");
      chk("t6 end pulses", 64'(end_cnt - e0), 64'd1);

      // reset in the middle of a payload
      add_start(8'hE0); add_len(16'd10); pkt.push_back(8'h0F);
      add_pay(8'h81, 1'b0, 1'b1); add_pay(8'h82, 1'b0, 1'b0); add_pay(8'h83, 1'b0, 1'b0);
      send_pkt();
      reset = 1'b1;
      send(8'h84); send(8'h85);
      reset = 1'b0;
      send(8'h86); send(8'h87);
      drain("t6 reset cut");
      chk("t6 out_valid",   64'(out_valid), 64'd0);
      chk("t6 start_valid", 64'(start_valid), 64'd0);
      chk("t6 start_time",  64'(start_time), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
